// File: rtl/cr16_pkg.sv
// Shared constants and types for the CR16 register file write path.
package cr16_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 16;

  typedef enum logic {
    S1_EMPTY = 1'b0,
    S1_FULL  = 1'b1
  } s1_state_t;

endpackage

// File: rtl/dec4_16.sv
// 4-to-16 one-hot decoder; output is all-zero when en is low.
module dec4_16
  import cr16_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] addr,
  output logic [15:0]           onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_wr_demux16.sv
// 16-entry register file with a two-stage (stage/commit) write path and read bypass.
// Optional macro REGFILE_R0_ZERO_EN makes register 0 a hardwired zero.
module regfile_wr_demux16
  import cr16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [REG_ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       commit_stall,
  input  logic [REG_ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        commit_strobe,
  output logic                       pending
);

  s1_state_t           state, state_nxt;
  logic [DATA_W-1:0]   s1_data;
  logic [NUM_REGS-1:0] s1_sel;
  logic [NUM_REGS-1:0] dec_onehot;
  logic [NUM_REGS-1:0] dec_sel;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                accept;
  logic                commit;

  assign pending  = (state == S1_FULL);
  assign wr_ready = ~pending | ~commit_stall;
  assign accept   = wr_valid & wr_ready;
  assign commit   = pending & ~commit_stall;

  dec4_16 u_dec (
    .en     (accept),
    .addr   (wr_addr),
    .onehot (dec_onehot)
  );

`ifdef REGFILE_R0_ZERO_EN
  // Address-0 writes still occupy S1 but carry an empty select, so they
  // neither load, strobe nor bypass.
  assign dec_sel = dec_onehot & ~NUM_REGS'(1);
`else
  assign dec_sel = dec_onehot;
`endif

  always_comb begin
    state_nxt = state;
    if (accept)      state_nxt = S1_FULL;
    else if (commit) state_nxt = S1_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S1_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data       <= '0;
      s1_sel        <= '0;
      commit_strobe <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      commit_strobe <= commit ? s1_sel : '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (commit && s1_sel[i]) regs[i] <= s1_data;
      if (accept) begin
        s1_data <= wr_data;
        s1_sel  <= dec_sel;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

  assign rd_data = (pending && s1_sel[rd_addr]) ? s1_data : regs[rd_addr];

endmodule

// File: tb/tb_regfile_wr_demux16.sv
// Scoreboard bench for regfile_wr_demux16: commits checked by a strobe monitor,
// bypass/stall/reset behaviour checked directly.
module tb_regfile_wr_demux16;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         commit_stall;
  logic [3:0]   rd_addr;
  logic [15:0]  rd_data;
  logic [255:0] regs_flat;
  logic [15:0]  commit_strobe;
  logic         pending;

  regfile_wr_demux16 #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit_stall  (commit_stall),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .regs_flat     (regs_flat),
    .commit_strobe (commit_strobe),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] strobe;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] reg_of(input logic [3:0] a);
    logic [255:0] f;
    f = regs_flat;
    return f[a*16 +: 16];
  endfunction

  // Monitor: every nonzero strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (!reset && commit_strobe != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 256'(commit_strobe), 256'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_strobe", 256'(commit_strobe), 256'(e.strobe));
        chk("commit_data", 256'(reg_of(e.addr)), 256'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d, input bit expect_commit);
    exp_t e;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    if (expect_commit) begin
      e.strobe = 16'h1 << a;
      e.addr   = a;
      e.data   = d;
      exp_q.push_back(e);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int waited;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_stall = 1'b0; rd_addr = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_regs", regs_flat, 256'(0));
    chk("reset_pending", 256'(pending), 256'(0));
    chk("reset_strobe", 256'(commit_strobe), 256'(0));
    chk("reset_wr_ready", 256'(wr_ready), 256'(1));

    // Basic write, monitor checks 0x0020 / 0xBEEF.
    write(4'd5, 16'hBEEF, 1'b1);
    tick(); tick();
    chk("reg5_after", 256'(reg_of(4'd5)), 256'(16'hBEEF));
    chk("strobe_one_cycle", 256'(commit_strobe), 256'(0));

    // Bypass read while staged.
    write(4'd3, 16'h1234, 1'b1);
    rd_addr = 4'd3;
    #1;
    chk("bypass_pending", 256'(pending), 256'(1));
    chk("bypass_rd_data", 256'(rd_data), 256'(16'h1234));
    chk("bypass_reg3_old", 256'(reg_of(4'd3)), 256'(0));
    tick(); tick();
    chk("rd_committed", 256'(rd_data), 256'(16'h1234));

    // Stall: held for 3 cycles; a write offered meanwhile must be ignored.
    commit_stall = 1'b1;
    write(4'd4, 16'h5555, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_wr_ready", 256'(wr_ready), 256'(0));
      chk("stall_pending", 256'(pending), 256'(1));
      chk("stall_reg4", 256'(reg_of(4'd4)), 256'(0));
      wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 16'h6666;
      tick();
    end
    wr_valid = 1'b0;
    commit_stall = 1'b0;
    #1;
    chk("release_wr_ready", 256'(wr_ready), 256'(1));
    tick();
    chk("release_reg4", 256'(reg_of(4'd4)), 256'(16'h5555));
    tick();

    // Back-to-back to the same register.
    write(4'd7, 16'h0001, 1'b1);
    chk("b2b_wr_ready", 256'(wr_ready), 256'(1));
    write(4'd7, 16'h0002, 1'b1);
    chk("b2b_pending", 256'(pending), 256'(1));
    tick(); tick();
    chk("b2b_reg7", 256'(reg_of(4'd7)), 256'(16'h0002));
    chk("ignored_reg6", 256'(reg_of(4'd6)), 256'(0));

    // Reset discards a staged write.
    write(4'd9, 16'hAAAA, 1'b0);
    chk("pre_reset_pending", 256'(pending), 256'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_pending", 256'(pending), 256'(0));
    chk("rst_reg9", 256'(reg_of(4'd9)), 256'(0));
    chk("rst_strobe", 256'(commit_strobe), 256'(0));
    chk("rst_all_regs", regs_flat, 256'(0));
    chk("rst_wr_ready", 256'(wr_ready), 256'(1));
    tick(); tick();

    // Register 0.
    rd_addr = 4'd0;
`ifdef REGFILE_R0_ZERO_EN
    write(4'd0, 16'hFFFF, 1'b0);
    #1;
    chk("r0_bypass", 256'(rd_data), 256'(0));
    tick(); tick();
    chk("r0_rd_data", 256'(rd_data), 256'(0));
    chk("r0_reg", 256'(reg_of(4'd0)), 256'(0));
`else
    write(4'd0, 16'hFFFF, 1'b1);
    #1;
    chk("r0_bypass", 256'(rd_data), 256'(16'hFFFF));
    tick(); tick();
    chk("r0_reg", 256'(reg_of(4'd0)), 256'(16'hFFFF));
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
